pzbcm_multi_grant_arbiter: RTL
==============================

Name: pzbcm_multi_grant_arbiter

Overview:
- Round-robin arbiter that grants up to GRANTS requesters at the same time, one per grant slot. It serves shared resources with several identical units, such as multi-port buffers or parallel engines.
- Each granted requester keeps its slot until it asserts i_free. When HOLD_LIMIT is non-zero, the slot is also released after a hold timeout.
- Successor to the single-grant keep-result arbiter core in the pzbcm_arbiter family.

Parameters:
- REQUESTS, 4: number of requesters; must be >= 2.
- GRANTS, 2: number of concurrent grant slots; must be 1..REQUESTS.
- HOLD_LIMIT, 0: maximum number of cycles a slot may be held; 0 disables the timeout.
- TIMER_WIDTH, calc_timer_width(HOLD_LIMIT): width of the per-slot hold counter; minimum 1.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_request  input  REQUESTS  level request, one bit per requester
- i_free  input  REQUESTS  release pulse for the slot held by requester r
- o_grant  output  GRANTS x REQUESTS  one-hot requester held by each slot; all zero when the slot is empty
- o_grant_valid  output  GRANTS  slot is occupied
- o_granted  output  REQUESTS  OR of all o_grant rows
- o_timeout  output  REQUESTS  one-cycle pulse in the final cycle of a timed-out hold
- o_full  output  1  all slots occupied

Behaviour:
- Reset: all slots empty. o_grant, o_grant_valid, o_granted, o_timeout and o_full are 0. Round-robin pointer is 0. Reset asserted mid-operation clears everything immediately; no frees or timeouts are reported.
- Slot state is registered; o_grant, o_grant_valid, o_granted and o_full are driven directly from registers.
- Latency: a request sampled in cycle t is visible on o_grant in cycle t+1.
- Eligible set = i_request & ~o_granted. A requester never occupies two slots.
- Allocation each cycle:
  - k = number of slots empty in the registered state.
  - Select up to k eligible requesters, scanning from the pointer upward modulo REQUESTS.
  - Place them into empty slots in ascending slot index.
  - Pointer becomes (last selected index + 1) mod REQUESTS. If nothing is selected, the pointer holds.
- Release:
  - i_free[r] with r held clears that slot at the next edge.
  - i_free[r] with r not held is ignored.
  - A slot released at edge e is not reallocated in the cycle preceding e; it is allocatable from the cycle after e. This guarantees a minimum one-cycle gap.
- Simultaneous frees on several slots are all honoured in the same cycle.
- Timeout (HOLD_LIMIT > 0):
  - Slot timer loads 0 on allocation and increments every occupied cycle.
  - In the cycle where timer == HOLD_LIMIT-1 and i_free of the holder is 0: o_timeout[holder] = 1 (combinational), and the slot clears at that edge.
  - The grant is therefore visible exactly HOLD_LIMIT cycles.
  - Free and timeout in the same cycle: the free wins and o_timeout stays 0.
- Timer saturates and never wraps. With HOLD_LIMIT = 0 the timer logic is removed and o_timeout is tied to 0.
- Requester deassertion: dropping i_request does not release a slot; only i_free or a timeout does.
- A requester still requesting after a timeout is treated as a new request and is subject to round-robin order.

Decomposition:
- pzbcm_arbiter_pkg: add function calc_timer_width(int hold_limit) returning max(1, clog2(hold_limit)).
- pzbcm_arbiter_pkg: add function find_next_k, a rotating priority picker returning the selected mask. It is reused by the top level.
- One sub-module: pzbcm_multi_grant_arbiter_slot. It holds one slot's one-hot register, valid bit and hold timer, and has load, free and timeout logic. It is instantiated GRANTS times in a generate loop.

Test Plan (REQUESTS=4, GRANTS=2, HOLD_LIMIT=0 unless stated):
1. Reset, then i_request=4'b1111 in cycle 0:
   - cycle 1: slot0=0001, slot1=0010, o_full=1, o_granted=0011.
   - i_free=0001 in cycle 2: cycle 3 slot0 empty; cycle 4 slot0=0100.
2. Fairness: i_request=4'b1111 held, with i_free pulsed each cycle on both holders. Over 8 allocations each requester is granted exactly 2 times, in order 0,1,2,3,0,1,2,3.
3. Stray free: i_free=1000 while slot0=0001 and slot1=0010. Slots unchanged; no timeout.
4. HOLD_LIMIT=3, only r3 requesting from cycle 0:
   - o_grant slot0=1000 in cycles 1-3; o_timeout=1000 in cycle 3 only.
   - Slot empty in cycle 4; re-granted in cycle 5.
   - i_free[3] in cycle 3 instead gives o_timeout=0.
5. Async reset asserted in cycle 2 of a hold with o_full=1: all outputs 0 before the next edge. After release, i_request=4'b0100 is granted on slot0 one cycle later, from pointer 0.
6. GRANTS=REQUESTS=4, i_request=4'b1111: all four slots filled in cycle 1 (slot i holds requester i). A new request while full produces no change until a free.

Source files
------------

// File: rtl/pzbcm_arbiter_pkg.sv
// Shared helpers for the pzbcm_arbiter family:
// timer sizing and a rotating k-of-n picker.
package pzbcm_arbiter_pkg;

  localparam int MAX_REQUESTS = 32;
  localparam int MAX_IDX_W    = $clog2(MAX_REQUESTS);

  typedef logic [MAX_REQUESTS-1:0] req_mask_t;

  function automatic int calc_timer_width(int hold_limit);
    int w;
    w = (hold_limit > 1) ? $clog2(hold_limit) : 1;
    return w;
  endfunction

  function automatic req_mask_t find_next_k(
    input  req_mask_t eligible,
    input  int        ptr,
    input  int        n,
    input  int        k,
    output int        next_ptr
  );
    req_mask_t mask;
    int        cnt;
    int        idx;
    mask     = '0;
    cnt      = 0;
    next_ptr = ptr;
    for (int i = 0; i < MAX_REQUESTS; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (eligible[idx[MAX_IDX_W-1:0]] && (cnt < k)) begin
          mask[idx[MAX_IDX_W-1:0]] = 1'b1;
          cnt      = cnt + 1;
          next_ptr = ((idx + 1) == n) ? 0 : idx + 1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pzbcm_multi_grant_arbiter_slot.sv
// One grant slot: holder one-hot, valid bit,
// optional hold timer with timeout release.
module pzbcm_multi_grant_arbiter_slot #(
  parameter int REQUESTS    = 4,
  parameter int HOLD_LIMIT  = 0,
  parameter int TIMER_WIDTH = 1
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [REQUESTS-1:0] i_load_grant,
  input  logic [REQUESTS-1:0] i_free,
  output logic [REQUESTS-1:0] o_grant,
  output logic                o_valid,
  output logic                o_timeout
);

  logic [REQUESTS-1:0] grant_q;
  logic                valid_q;
  logic                free_hit;
  logic                timeout;
  logic                load;

  assign free_hit = valid_q && (|(i_free & grant_q));
  assign load     = i_load && !valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q <= '0;
      valid_q <= 1'b0;
    end else if (free_hit || timeout) begin
      grant_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      grant_q <= i_load_grant;
      valid_q <= 1'b1;
    end
  end

  if (HOLD_LIMIT > 0) begin : g_timer
    localparam logic [TIMER_WIDTH-1:0] LAST =
      TIMER_WIDTH'(HOLD_LIMIT - 1);
    logic [TIMER_WIDTH-1:0] timer_q;

    // A free in the final cycle takes priority over the timeout
    assign timeout = valid_q && !free_hit &&
                     (timer_q == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        timer_q <= '0;
      end else if (load) begin
        timer_q <= '0;
      end else if (valid_q && (timer_q != LAST)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end else begin : g_no_timer
    assign timeout = 1'b0;
  end

  assign o_grant   = grant_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout;

endmodule

// File: rtl/pzbcm_multi_grant_arbiter.sv
// Round-robin arbiter granting up to GRANTS
// requesters at once, each held until free/timeout.
module pzbcm_multi_grant_arbiter
  import pzbcm_arbiter_pkg::*;
#(
  parameter int REQUESTS    = 4,
  parameter int GRANTS      = 2,
  parameter int HOLD_LIMIT  = 0,
  parameter int TIMER_WIDTH = calc_timer_width(HOLD_LIMIT)
)(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [REQUESTS-1:0]              i_request,
  input  logic [REQUESTS-1:0]              i_free,
  output logic [GRANTS-1:0][REQUESTS-1:0]  o_grant,
  output logic [GRANTS-1:0]                o_grant_valid,
  output logic [REQUESTS-1:0]              o_granted,
  output logic [REQUESTS-1:0]              o_timeout,
  output logic                             o_full
);

  localparam int PTR_W = $clog2(REQUESTS);

  logic [PTR_W-1:0]                ptr_q;
  logic [PTR_W-1:0]                ptr_d;
  logic [GRANTS-1:0][REQUESTS-1:0] slot_grant;
  logic [GRANTS-1:0]               slot_valid;
  logic [GRANTS-1:0]               slot_timeout;
  logic [GRANTS-1:0][REQUESTS-1:0] load_grant;
  logic [GRANTS-1:0]               load;
  logic [REQUESTS-1:0]             granted;
  logic [REQUESTS-1:0]             sel;
  req_mask_t                       elig_w;
  req_mask_t                       sel_wide_unused;
  int                              k;
  int                              nxt;
  int                              rank;
  int                              req_rank  [REQUESTS];
  int                              slot_rank [GRANTS];

  always_comb begin
    granted   = '0;
    o_timeout = '0;
    for (int g = 0; g < GRANTS; g++) begin
      granted   = granted | slot_grant[g];
      o_timeout = o_timeout |
        (slot_grant[g] & {REQUESTS{slot_timeout[g]}});
    end
  end

  always_comb begin
    elig_w                 = '0;
    elig_w[REQUESTS-1:0]   = i_request & ~granted;
    k                      = 0;
    for (int g = 0; g < GRANTS; g++) begin
      slot_rank[g] = k;
      if (!slot_valid[g]) k = k + 1;
    end
    nxt             = 0;
    sel_wide_unused = find_next_k(
      elig_w, int'(ptr_q), REQUESTS, k, nxt);
    sel   = sel_wide_unused[REQUESTS-1:0];
    ptr_d = PTR_W'(nxt);
    // Rank winners in scan order from the pointer
    rank  = 0;
    for (int r = 0; r < REQUESTS; r++) req_rank[r] = 0;
    for (int i = 0; i < REQUESTS; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= REQUESTS) idx = idx - REQUESTS;
      if (sel[idx]) begin
        req_rank[idx] = rank;
        rank          = rank + 1;
      end
    end
    // n-th winner goes to the n-th empty slot
    for (int g = 0; g < GRANTS; g++) begin
      for (int r = 0; r < REQUESTS; r++) begin
        load_grant[g][r] = !slot_valid[g] && sel[r] &&
                           (req_rank[r] == slot_rank[g]);
      end
      load[g] = |load_grant[g];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar g = 0; g < GRANTS; g++) begin : g_slot
    pzbcm_multi_grant_arbiter_slot #(
      .REQUESTS    (REQUESTS),
      .HOLD_LIMIT  (HOLD_LIMIT),
      .TIMER_WIDTH (TIMER_WIDTH)
    ) u_slot (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (load[g]),
      .i_load_grant (load_grant[g]),
      .i_free       (i_free),
      .o_grant      (slot_grant[g]),
      .o_valid      (slot_valid[g]),
      .o_timeout    (slot_timeout[g])
    );
  end

  assign o_grant       = slot_grant;
  assign o_grant_valid = slot_valid;
  assign o_granted     = granted;
  assign o_full        = &slot_valid;

endmodule
